// File: rtl/checkbits_seq_monitor.sv
// rtl/checkbits_seq_monitor.sv - watches a 16-bit status bus for a programmed sequence of stable values
module checkbits_seq_monitor #(
    parameter int NUM_EXP       = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int TMO_W         = 24
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [15:0]      checkbits,
    input  logic             start,
    input  logic [3:0]       seq_len,
    input  logic [TMO_W-1:0] timeout_limit,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [15:0]      cfg_data,
    output logic             busy,
    output logic             step_hit,
    output logic [2:0]       step_idx,
    output logic [TMO_W-1:0] step_cycles,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code
);

    localparam int                 STAB_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0]  LP_STAB_MAX = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0]  LP_STAB_ONE = STAB_W'(1);
    localparam logic [TMO_W-1:0]   LP_TMR_ONE  = TMO_W'(1);
    localparam logic [3:0]         LP_NUM_EXP  = 4'(NUM_EXP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_chk_q;
    logic [STAB_W-1:0]  r_stab;
    logic               r_consumed;
    logic [2:0]         r_idx;
    logic [2:0]         r_last_idx;
    logic [TMO_W-1:0]   r_timer;
    logic               r_step_hit;
    logic [2:0]         r_step_idx;
    logic [TMO_W-1:0]   r_step_cycles;
    logic [1:0]         r_fail_code;
    logic [15:0]        r_exp [NUM_EXP];

    logic               w_chg;
    logic               w_stable;
    logic               w_len_ok;
    logic [15:0]        w_exp_cur;
    logic               w_match;
    logic               w_timeout;
    logic               w_arm;
    logic               w_bad_len;

    // A change is seen as the sampling flop loads a value different from what it holds.
    assign w_chg     = (checkbits != r_chk_q);
    assign w_stable  = (r_stab == LP_STAB_MAX);
    assign w_len_ok  = (seq_len != 4'd0) && (seq_len <= LP_NUM_EXP);
    assign w_exp_cur = r_exp[r_idx];

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_match     = 1'b0;
        w_timeout   = 1'b0;
        w_arm       = 1'b0;
        w_bad_len   = 1'b0;
        case (r_state)
            S_WAIT: begin
                w_match   = w_stable && !r_consumed && (r_chk_q == w_exp_cur);
                w_timeout = !w_match && (timeout_limit != '0) && (r_timer == timeout_limit);
                if (w_match) begin
                    if (r_idx == r_last_idx) begin
                        w_state_nxt = S_PASS;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_FAIL;
                end
            end
            default: begin
                if (start) begin
                    if (w_len_ok) begin
                        w_arm       = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_bad_len   = 1'b1;
                        w_state_nxt = S_FAIL;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_chk_q       <= '0;
            r_stab        <= '0;
            r_consumed    <= 1'b0;
            r_idx         <= '0;
            r_last_idx    <= '0;
            r_timer       <= '0;
            r_step_hit    <= 1'b0;
            r_step_idx    <= '0;
            r_step_cycles <= '0;
            r_fail_code   <= 2'b00;
            for (int i = 0; i < NUM_EXP; i++) begin
                r_exp[i] <= '0;
            end
        end else begin
            r_chk_q    <= checkbits;
            r_step_hit <= w_match;

            if (w_chg) begin
                r_stab <= '0;
            end else if (!w_stable) begin
                r_stab <= r_stab + LP_STAB_ONE;
            end

            // A new value always re-arms, even if it lands on the matching cycle.
            if (w_chg) begin
                r_consumed <= 1'b0;
            end else if (w_match) begin
                r_consumed <= 1'b1;
            end

            if (w_arm) begin
                r_idx       <= '0;
                r_timer     <= '0;
                r_last_idx  <= seq_len[2:0] - 3'd1;
                r_fail_code <= 2'b00;
            end else if (w_bad_len) begin
                r_fail_code <= 2'b10;
            end else if (w_match) begin
                r_step_idx    <= r_idx;
                r_step_cycles <= r_timer;
                r_timer       <= '0;
                if (r_idx != r_last_idx) begin
                    r_idx <= r_idx + 3'd1;
                end
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + LP_TMR_ONE;
                if (w_timeout) begin
                    r_fail_code <= 2'b01;
                end
            end

            if (cfg_we && (r_state != S_WAIT)) begin
                r_exp[cfg_addr] <= cfg_data;
            end
        end
    end

    assign busy        = (r_state == S_WAIT);
    assign pass        = (r_state == S_PASS);
    assign fail        = (r_state == S_FAIL);
    assign step_hit    = r_step_hit;
    assign step_idx    = r_step_idx;
    assign step_cycles = r_step_cycles;
    assign fail_code   = r_fail_code;

endmodule

// File: tb/tb_checkbits_seq_monitor.sv
// tb/tb_checkbits_seq_monitor.sv - directed self-checking bench for checkbits_seq_monitor
module tb_checkbits_seq_monitor;

    logic        clock = 1'b0;
    logic        resetb;
    logic [15:0] checkbits;
    logic        start;
    logic [3:0]  seq_len;
    logic [23:0] timeout_limit;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        busy;
    logic        step_hit;
    logic [2:0]  step_idx;
    logic [23:0] step_cycles;
    logic        pass;
    logic        fail;
    logic [1:0]  fail_code;

    int n_total = 0;
    int n_bad   = 0;
    int n_hits  = 0;
    int hit_log[$];
    logic [15:0] tbl_a [6] = '{16'hAB40, 16'h003E, 16'h0044, 16'h004A, 16'h0050, 16'hAB51};

    checkbits_seq_monitor #(
        .NUM_EXP      (8),
        .STABLE_CYCLES(4),
        .TMO_W        (24)
    ) dut (
        .clock        (clock),
        .resetb       (resetb),
        .checkbits    (checkbits),
        .start        (start),
        .seq_len      (seq_len),
        .timeout_limit(timeout_limit),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .busy         (busy),
        .step_hit     (step_hit),
        .step_idx     (step_idx),
        .step_cycles  (step_cycles),
        .pass         (pass),
        .fail         (fail),
        .fail_code    (fail_code)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (step_hit) begin
            n_hits = n_hits + 1;
            hit_log.push_back(int'(step_idx));
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
        cfg_addr = a;
        cfg_data = d;
        cfg_we   = 1'b1;
        cyc(1);
        cfg_we   = 1'b0;
    endtask

    task automatic load_a();
        for (int i = 0; i < 6; i++) begin
            cfg_write(3'(i), tbl_a[i]);
        end
    endtask

    task automatic pulse_start(input logic [3:0] len);
        seq_len = len;
        start   = 1'b1;
        cyc(1);
        start   = 1'b0;
    endtask

    task automatic drive(input logic [15:0] v, input int n);
        checkbits = v;
        cyc(n);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_busy"},   32'(busy),        32'd0);
        check_val({pfx, "_hit"},    32'(step_hit),    32'd0);
        check_val({pfx, "_idx"},    32'(step_idx),    32'd0);
        check_val({pfx, "_cycles"}, 32'(step_cycles), 32'd0);
        check_val({pfx, "_pass"},   32'(pass),        32'd0);
        check_val({pfx, "_fail"},   32'(fail),        32'd0);
        check_val({pfx, "_code"},   32'(fail_code),   32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetb        = 1'b0;
        start         = 1'b0;
        seq_len       = 4'd0;
        timeout_limit = 24'd0;
        cfg_we        = 1'b0;
        cfg_addr      = 3'd0;
        cfg_data      = 16'h0;
        checkbits     = 16'h0;
        #1;
        check_reset_outputs("por");
        cyc(2);
        resetb = 1'b1;
        cyc(2);

        // Full six-step sequence, plus exact hit latency and step timing.
        load_a();
        timeout_limit = 24'd5000;
        n_hits = 0;
        hit_log.delete();
        pulse_start(4'd6);
        check_val("seq_busy", 32'(busy), 32'd1);
        checkbits = tbl_a[0];
        cyc(4);
        check_val("lat_early", 32'(step_hit), 32'd0);
        cyc(1);
        check_val("lat_hit", 32'(step_hit), 32'd1);
        check_val("lat_cycles", 32'(step_cycles), 32'd4);
        cyc(1);
        check_val("hit_pulse", 32'(step_hit), 32'd0);
        cyc(14);
        for (int i = 1; i < 6; i++) begin
            drive(tbl_a[i], 20);
        end
        check_val("seq_hits", 32'(n_hits), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("seq_log%0d", i),
                      (i < hit_log.size()) ? 32'(hit_log[i]) : 32'hDEAD, 32'(i));
        end
        check_val("seq_pass", 32'(pass), 32'd1);
        check_val("seq_fail", 32'(fail), 32'd0);
        check_val("seq_idle", 32'(busy), 32'd0);
        check_val("seq_cycles", 32'(step_cycles), 32'd19);

        // Short glitch to the next expected value must not count.
        n_hits = 0;
        pulse_start(4'd6);
        drive(16'hAB40, 20);
        drive(16'h003E, 20);
        drive(16'h0044, 2);
        drive(16'h003E, 20);
        check_val("glitch_hits", 32'(n_hits), 32'd2);
        check_val("glitch_idx", 32'(step_idx), 32'd1);
        check_val("glitch_busy", 32'(busy), 32'd1);
        drive(16'h0044, 20);
        drive(16'h004A, 20);
        drive(16'h0050, 20);
        drive(16'hAB51, 20);
        check_val("glitch_total", 32'(n_hits), 32'd6);
        check_val("glitch_pass", 32'(pass), 32'd1);

        // Repeated table entry needs an intervening different value.
        cfg_write(3'd0, 16'h0011);
        cfg_write(3'd1, 16'h0011);
        n_hits = 0;
        pulse_start(4'd2);
        drive(16'h0011, 100);
        check_val("rep_one", 32'(n_hits), 32'd1);
        check_val("rep_idx", 32'(step_idx), 32'd0);
        check_val("rep_busy", 32'(busy), 32'd1);
        drive(16'h0000, 10);
        drive(16'h0011, 20);
        check_val("rep_two", 32'(n_hits), 32'd2);
        check_val("rep_idx2", 32'(step_idx), 32'd1);
        check_val("rep_pass", 32'(pass), 32'd1);

        // Timeout at exactly timer == 50.
        cfg_write(3'd0, 16'h1234);
        checkbits = 16'h0000;
        timeout_limit = 24'd50;
        cyc(5);
        pulse_start(4'd1);
        cyc(50);
        check_val("tmo_before", 32'(fail), 32'd0);
        check_val("tmo_busy", 32'(busy), 32'd1);
        cyc(1);
        check_val("tmo_fail", 32'(fail), 32'd1);
        check_val("tmo_code", 32'(fail_code), 32'd1);
        check_val("tmo_pass", 32'(pass), 32'd0);
        check_val("tmo_idle", 32'(busy), 32'd0);

        // Match in the same cycle the timer reaches the limit wins.
        pulse_start(4'd1);
        cyc(46);
        checkbits = 16'h1234;
        cyc(4);
        check_val("race_early", 32'(step_hit), 32'd0);
        cyc(1);
        check_val("race_hit", 32'(step_hit), 32'd1);
        check_val("race_cycles", 32'(step_cycles), 32'd50);
        check_val("race_fail", 32'(fail), 32'd0);
        check_val("race_pass", 32'(pass), 32'd1);

        // Illegal lengths, start ignored while busy, cfg write dropped while busy.
        pulse_start(4'd0);
        check_val("len0_fail", 32'(fail), 32'd1);
        check_val("len0_code", 32'(fail_code), 32'd2);
        timeout_limit = 24'd0;
        pulse_start(4'd1);
        check_val("rearm_busy", 32'(busy), 32'd1);
        check_val("rearm_code", 32'(fail_code), 32'd0);
        cfg_write(3'd0, 16'h5678);
        pulse_start(4'd9);
        check_val("ign_busy", 32'(busy), 32'd1);
        check_val("ign_fail", 32'(fail), 32'd0);
        drive(16'h0000, 10);
        drive(16'h1234, 10);
        check_val("cfg_drop", 32'(pass), 32'd1);
        pulse_start(4'd9);
        check_val("len9_fail", 32'(fail), 32'd1);
        check_val("len9_code", 32'(fail_code), 32'd2);
        check_val("len9_pass", 32'(pass), 32'd0);

        // Asynchronous reset in the middle of a sequence.
        load_a();
        timeout_limit = 24'd5000;
        pulse_start(4'd6);
        drive(16'hAB40, 20);
        drive(16'h003E, 20);
        drive(16'h0044, 5);
        check_val("pre_rst_hit", 32'(step_hit), 32'd1);
        check_val("pre_rst_idx", 32'(step_idx), 32'd2);
        #2;
        resetb = 1'b0;
        #1;
        check_reset_outputs("arst");
        cyc(2);
        resetb = 1'b1;
        cyc(3);
        check_val("post_rst_idle", 32'(busy), 32'd0);
        load_a();
        n_hits = 0;
        pulse_start(4'd6);
        drive(16'hAB40, 5);
        check_val("restart_hit", 32'(step_hit), 32'd1);
        check_val("restart_idx", 32'(step_idx), 32'd0);
        drive(16'hAB40, 10);
        check_val("restart_count", 32'(n_hits), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
